// File: rtl/sme_param.sv
// Parametrised string-match engine: loads patterns from pattern ROM and then scans a text ROM once per pattern.
// Reports every match position, including overlapping ones, with the pattern index and the text start address.
module sme_param #(
  parameter int PAT_NUM = 16,
  parameter int PAT_LEN = 16,
  parameter int T_AW    = 12,
  parameter int P_AW    = 8,
  parameter int PNW     = $clog2(PAT_NUM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            case_insensitive,
  output logic            busy,
  output logic [PNW-1:0]  pattern_no,
  output logic [T_AW-1:0] match_addr,
  output logic            valid,
  output logic            finish,
  output logic            ovf,
  output logic [T_AW-1:0] T_addr,
  input  logic [7:0]      T_data,
  output logic [P_AW-1:0] P_addr,
  input  logic [7:0]      P_data
);

  localparam int PCW = $clog2(PAT_NUM + 1);
  localparam int ECW = $clog2(PAT_LEN + 1);
  localparam int EIW = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  localparam logic [T_AW-1:0] T_MAX = {T_AW{1'b1}};
  localparam logic [P_AW-1:0] P_MAX = {P_AW{1'b1}};

  typedef enum logic [2:0] {IDLE, LOAD_P, SCAN, NEXT_PAT, DONE} state_t;
  typedef enum logic [2:0] {PH_PROBE_RD, PH_PROBE, PH_EVAL, PH_EL_RD, PH_CMP, PH_ADV} phase_t;
  typedef enum logic [1:0] {EK_LIT, EK_ANY, EK_CARET, EK_DOLLAR} ekind_t;

  state_t state_q, state_d;
  phase_t phase_q;

  ekind_t         pk_mem   [PAT_NUM][PAT_LEN];
  logic [7:0]     pc_mem   [PAT_NUM][PAT_LEN];
  logic [ECW-1:0] plen_mem [PAT_NUM];

  logic           p_ph_q, esc_q, in_pat_q, ci_q, prev_nl_q, is_last_q;
  logic [PCW-1:0] pat_cnt_q, n_pat_q;
  logic [ECW-1:0] byte_cnt_q, elem_cnt_q, e_q;
  logic [PNW-1:0] k_q;
  logic [T_AW-1:0] s_q, ta_q;
  logic [7:0]     probe_c_q;

  logic           p_at_max, ld_act, ld_skip, ld_byte, ld_keep, ld_close, ld_store, ld_end, wr_el;
  logic [PCW-1:0] ld_npat;
  logic [7:0]     wr_chr;
  ekind_t         wr_kind;

  logic [7:0]     t_char, cur_chr;
  ekind_t         cur_kind;
  logic [ECW-1:0] cur_len;
  logic           anchor_caret, anchor_dollar, caret_ok, lit_eq, cmp_ok, k_more, scan_done;

  function automatic logic [7:0] fold(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5A) ? (c | 8'h20) : c;
  endfunction

  // Handshake: start is a one-cycle request honoured only while busy=0 (IDLE or DONE);
  // busy stays high until the engine reaches DONE, where finish rises and holds.
  assign busy   = (state_q == LOAD_P) || (state_q == SCAN) || (state_q == NEXT_PAT);
  assign finish = (state_q == DONE);

  // Pattern loading: one byte consumed every other cycle, on the cycle its data is valid.
  always_comb begin
    p_at_max = (P_addr == P_MAX);
    ld_act   = (state_q == LOAD_P) && p_ph_q;
    ld_skip  = (pat_cnt_q == PCW'(PAT_NUM));
    ld_byte  = ld_act && !p_at_max && (P_data != 8'h00);
    ld_keep  = ld_byte && !ld_skip && (byte_cnt_q != ECW'(PAT_LEN));
    ld_close = ld_act && in_pat_q && (p_at_max || P_data == 8'h00);
    ld_store = ld_close && !ld_skip;
    ld_end   = ld_act && (p_at_max || (P_data == 8'h00 && !in_pat_q));
    ld_npat  = pat_cnt_q + PCW'(ld_store);
    wr_el    = (ld_keep && (esc_q || P_data != 8'h5C)) || (ld_store && esc_q);
    wr_chr   = ld_store ? 8'h5C : P_data;
    wr_kind  = EK_LIT;
    if (!esc_q && !ld_store) begin
      case (P_data)
        8'h2E:   wr_kind = EK_ANY;
        8'h5E:   wr_kind = EK_CARET;
        8'h24:   wr_kind = EK_DOLLAR;
        default: wr_kind = EK_LIT;
      endcase
    end
  end

  // The last text address is never part of the text, so it reads as a terminator.
  always_comb begin
    t_char        = (T_addr == T_MAX) ? 8'h00 : T_data;
    cur_len       = plen_mem[k_q];
    cur_kind      = pk_mem[k_q][e_q[EIW-1:0]];
    cur_chr       = pc_mem[k_q][e_q[EIW-1:0]];
    anchor_caret  = (cur_kind == EK_CARET) && (e_q == '0);
    anchor_dollar = (cur_kind == EK_DOLLAR) && ((e_q + ECW'(1)) == cur_len);
    caret_ok      = (s_q == '0) || prev_nl_q;
    lit_eq        = ci_q ? (fold(t_char) == fold(cur_chr)) : (t_char == cur_chr);
    if (anchor_dollar)          cmp_ok = (t_char == 8'h0A) || (t_char == 8'h00);
    else if (cur_kind == EK_ANY) cmp_ok = (t_char != 8'h00) && (t_char != 8'h0A);
    else                        cmp_ok = (t_char != 8'h00) && lit_eq;
    k_more    = (PCW'(k_q) + PCW'(1)) < n_pat_q;
    scan_done = (phase_q == PH_ADV) && is_last_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = LOAD_P;
      LOAD_P:     if (ld_end) state_d = (ld_npat == '0) ? DONE : SCAN;
      SCAN:       if (scan_done) state_d = NEXT_PAT;
      NEXT_PAT:   state_d = k_more ? SCAN : DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (wr_el) begin
      pk_mem[pat_cnt_q[PNW-1:0]][elem_cnt_q[EIW-1:0]] <= wr_kind;
      pc_mem[pat_cnt_q[PNW-1:0]][elem_cnt_q[EIW-1:0]] <= wr_chr;
    end
    if (ld_store) plen_mem[pat_cnt_q[PNW-1:0]] <= elem_cnt_q + ECW'(esc_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0; ovf <= 1'b0; pattern_no <= '0; match_addr <= '0;
      T_addr <= '0; P_addr <= '0; phase_q <= PH_PROBE_RD;
      p_ph_q <= 1'b0; esc_q <= 1'b0; in_pat_q <= 1'b0; ci_q <= 1'b0;
      prev_nl_q <= 1'b0; is_last_q <= 1'b0; pat_cnt_q <= '0; n_pat_q <= '0;
      byte_cnt_q <= '0; elem_cnt_q <= '0; e_q <= '0; k_q <= '0;
      s_q <= '0; ta_q <= '0; probe_c_q <= '0;
    end else begin
      valid <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            ovf <= 1'b0; P_addr <= '0; p_ph_q <= 1'b0; pat_cnt_q <= '0;
            byte_cnt_q <= '0; elem_cnt_q <= '0; esc_q <= 1'b0; in_pat_q <= 1'b0;
            ci_q <= case_insensitive;
          end
        end
        LOAD_P: begin
          p_ph_q <= ~p_ph_q;
          if (ld_act && !p_at_max) P_addr <= P_addr + P_AW'(1);
          if (ld_byte) begin
            in_pat_q <= 1'b1;
            if (!ld_keep) ovf <= 1'b1;
            else begin
              byte_cnt_q <= byte_cnt_q + ECW'(1);
              if (esc_q) begin
                esc_q <= 1'b0; elem_cnt_q <= elem_cnt_q + ECW'(1);
              end else if (P_data == 8'h5C) esc_q <= 1'b1;
              else elem_cnt_q <= elem_cnt_q + ECW'(1);
            end
          end
          if (ld_close) begin
            in_pat_q <= 1'b0; byte_cnt_q <= '0; elem_cnt_q <= '0; esc_q <= 1'b0;
            if (!ld_skip) pat_cnt_q <= pat_cnt_q + PCW'(1);
          end
          if (ld_end) begin
            n_pat_q <= ld_npat; k_q <= '0; s_q <= '0; T_addr <= '0;
            prev_nl_q <= 1'b0; is_last_q <= 1'b0; phase_q <= PH_PROBE_RD;
          end
        end
        SCAN: begin
          case (phase_q)
            PH_PROBE_RD: phase_q <= PH_PROBE;
            PH_PROBE: begin
              probe_c_q <= t_char; is_last_q <= (t_char == 8'h00);
              ta_q <= s_q; e_q <= '0; phase_q <= PH_EVAL;
            end
            PH_EVAL: begin
              if (e_q == cur_len) begin
                valid <= 1'b1; pattern_no <= k_q; match_addr <= s_q; phase_q <= PH_ADV;
              end else if (anchor_caret) begin
                if (caret_ok) e_q <= e_q + ECW'(1);
                else          phase_q <= PH_ADV;
              end else begin
                T_addr <= ta_q; phase_q <= PH_EL_RD;
              end
            end
            PH_EL_RD: phase_q <= PH_CMP;
            PH_CMP: begin
              if (cmp_ok) begin
                e_q <= e_q + ECW'(1);
                if (!anchor_dollar) ta_q <= ta_q + T_AW'(1);
                phase_q <= PH_EVAL;
              end else phase_q <= PH_ADV;
            end
            PH_ADV: begin
              if (!is_last_q) begin
                s_q <= s_q + T_AW'(1); T_addr <= s_q + T_AW'(1);
                prev_nl_q <= (probe_c_q == 8'h0A); phase_q <= PH_PROBE_RD;
              end
            end
            default: phase_q <= PH_PROBE_RD;
          endcase
        end
        NEXT_PAT: begin
          if (k_more) begin
            k_q <= k_q + PNW'(1); s_q <= '0; T_addr <= '0;
            prev_nl_q <= 1'b0; is_last_q <= 1'b0; phase_q <= PH_PROBE_RD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
